// File: rtl/pagerank_seq_sum.sv
// Sequential PageRank reducer: sums masked partial ranks one lane per cycle across the
// beats of one destination node, then applies damping and hands the result to write-back.
module pagerank_seq_sum #(
  parameter int unsigned    LANES = 10,
  parameter int unsigned    W     = 32,
  parameter logic [15:0]    DAMP  = 16'd55706,
  parameter logic [W-1:0]   BASE  = '0,
  parameter int unsigned    IDXW  = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [LANES*W-1:0]   in_data,
  input  logic [LANES-1:0]     in_mask,
  input  logic                 in_last,
  input  logic [IDXW-1:0]      in_node,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [W-1:0]         out_pr,
  output logic [IDXW-1:0]      out_node,
  output logic                 out_sat
);

  localparam int unsigned CW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [CW-1:0] LAST_LANE = CW'(LANES - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_SCAN = 3'd1;
  localparam logic [2:0] S_MUL  = 3'd2;
  localparam logic [2:0] S_DAMP = 3'd3;
  localparam logic [2:0] S_OUT  = 3'd4;

  logic [2:0]          state;
  logic [LANES*W-1:0]  data_q;
  logic [LANES-1:0]    mask_q;
  logic                last_q;
  logic [IDXW-1:0]     node_q;
  logic [CW-1:0]       lane_cnt;
  logic [W-1:0]        acc;
  logic                sat;
  logic [W-1:0]        prod_q;

  // Beat registers shift down one lane per SCAN cycle, so lane k is always in the low slot.
  logic [W-1:0] lane_val;
  logic         acc_carry;
  logic [W-1:0] acc_sum;
  logic [W-1:0] acc_next;
  logic [W-1:0] prod_next;
  logic         res_carry;
  logic [W-1:0] res_sum;

  assign lane_val               = data_q[W-1:0];
  assign {acc_carry, acc_sum}   = {1'b0, acc} + {1'b0, lane_val};
  assign acc_next               = acc_carry ? '1 : acc_sum;
  assign prod_next              = W'(({16'b0, acc} * {{W{1'b0}}, DAMP}) >> 16);
  assign {res_carry, res_sum}   = {1'b0, prod_q} + {1'b0, BASE};

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_OUT);

  // The wide multiply is registered in S_MUL so it never shares a cycle with the
  // damping add and its saturation compare.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: beat registers are reset too; they are plain flops, not a RAM, and a known
      // value after reset keeps partial sums from ever picking up stale lane data.
      state    <= S_IDLE;
      data_q   <= '0;
      mask_q   <= '0;
      last_q   <= 1'b0;
      node_q   <= '0;
      lane_cnt <= '0;
      acc      <= '0;
      sat      <= 1'b0;
      prod_q   <= '0;
      out_pr   <= '0;
      out_node <= '0;
      out_sat  <= 1'b0;
    end else begin
      // NOTE: every state register here uses <= so all of them update from the same
      // pre-edge values, independent of statement order.
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            data_q   <= in_data;
            mask_q   <= in_mask;
            last_q   <= in_last;
            if (in_last) node_q <= in_node;
            lane_cnt <= '0;
            state    <= S_SCAN;
          end
        end

        S_SCAN: begin
          if (mask_q[0]) begin
            acc <= acc_next;
            if (acc_carry) sat <= 1'b1;
          end
          data_q   <= data_q >> W;
          mask_q   <= mask_q >> 1;
          lane_cnt <= lane_cnt + CW'(1);
          if (lane_cnt == LAST_LANE) state <= last_q ? S_MUL : S_IDLE;
        end

        S_MUL: begin
          prod_q <= prod_next;
          state  <= S_DAMP;
        end

        S_DAMP: begin
          out_pr   <= res_carry ? '1 : res_sum;
          out_node <= node_q;
          out_sat  <= sat | res_carry;
          state    <= S_OUT;
        end

        S_OUT: begin
          if (out_ready) begin
            acc   <= '0;
            sat   <= 1'b0;
            state <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
